divided_clock_monitor: RTL

- Sits directly downstream of Clock_divider and consumes its clock_out as a sampled data signal in the clock_in domain.
- Measures the period and high time of the divided clock in clock_in cycles, and checks them against the expected divisor.
- Asserts locked after a run of good periods; flags period, duty and stall errors.
- Used as a built-in self-check of the divider in simulation and on hardware.

---
 rtl/divided_clock_monitor_pkg.sv | 7 +
 rtl/divided_clock_monitor_edge_sync_detect.sv | 25 ++
 rtl/divided_clock_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/divided_clock_monitor_pkg.sv
// divided_clock_monitor_pkg: monitor state encodings and synchronizer depth
package divided_clock_monitor_pkg;
    localparam int SYNC_STAGES = 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEEK = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;
endpackage

// File: rtl/divided_clock_monitor_edge_sync_detect.sv
// edge_sync_detect: synchronizes a slow clock sampled as data and pulses rise on its rising edge
// ports: clk, rst (sync, active-high), d (async in), s (synchronized level), rise (one-cycle pulse)
module edge_sync_detect
    import divided_clock_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic s_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            s_d  <= sync[SYNC_STAGES-1];
        end
    end
    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
endmodule

// File: rtl/divided_clock_monitor.sv
// divided_clock_monitor: measures period/high time of a divided clock and flags lock, period, duty and stall errors
// ports: clock_in, reset (sync, active-high), enable, div_clk_in -> period_out, high_out, meas_valid,
//        locked, period_err, duty_err, stall (sticky flags), err_count (saturating)
module divided_clock_monitor
    import divided_clock_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 2,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             period_err,
    output logic             duty_err,
    output logic             stall,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    logic [1:0]       state;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [RUN_W-1:0] good_run;
    logic [CNT_W:0]   per_ext;
    logic [ERR_W-1:0] err_inc;
    logic             s, rise, per_bad, duty_bad;
    edge_sync_detect u_sync (
        .clk  (clock_in),
        .rst  (reset),
        .d    (div_clk_in),
        .s    (s),
        .rise (rise)
    );
    // one extra bit keeps EXP_PERIOD-TOL from underflowing and EXP_PERIOD+TOL from overflowing
    assign per_ext  = {1'b0, per_cnt};
    assign per_bad  = (per_ext + (CNT_W+1)'(TOL) < (CNT_W+1)'(EXP_PERIOD)) ||
                      (per_ext > (CNT_W+1)'(EXP_PERIOD + TOL));
    assign duty_bad = (hi_cnt == '0) || (hi_cnt >= per_cnt);
    assign err_inc  = err_count + ERR_W'(err_count != '1);
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            good_run   <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            period_err <= 1'b0;
            duty_err   <= 1'b0;
            stall      <= 1'b0;
            err_count  <= '0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                locked   <= 1'b0;
                good_run <= '0;
                per_cnt  <= '0;
                hi_cnt   <= '0;
            end else if (state == IDLE) begin
                state <= SEEK;
            end else if (rise) begin
                // a rise in SEEK only opens the first measurement window
                state   <= MEAS;
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
                if (state == MEAS) begin
                    period_out <= per_cnt;
                    high_out   <= hi_cnt;
                    meas_valid <= 1'b1;
                    if (per_bad || duty_bad) begin
                        good_run   <= '0;
                        locked     <= 1'b0;
                        err_count  <= err_inc;
                        period_err <= period_err | per_bad;
                        duty_err   <= duty_err | duty_bad;
                    end else begin
                        good_run <= (good_run == RUN_W'(LOCK_COUNT)) ? good_run : good_run + RUN_W'(1);
                        if (good_run >= RUN_W'(LOCK_COUNT - 1))
                            locked <= 1'b1;
                    end
                end
            end else if (state == MEAS) begin
                if (per_cnt == CNT_MAX) begin
                    stall     <= 1'b1;
                    locked    <= 1'b0;
                    good_run  <= '0;
                    err_count <= err_inc;
                    state     <= SEEK;
                    per_cnt   <= '0;
                    hi_cnt    <= '0;
                end else begin
                    per_cnt <= per_cnt + CNT_W'(1);
                    hi_cnt  <= hi_cnt + CNT_W'(s);
                end
            end
        end
    end
endmodule
